// File: rtl/hamming_error_sweep.sv
// hamming_error_sweep: drives single-bit error injection trials through the
// Hamming(7,4) encoder -> corrupter -> decoder chain and scores the decoder.
// Each trial presents a codeword plus a corrupter index (0 = clean, 1..7 =
// flip that bit), waits for the decoder result and counts pass/fail.
module hamming_error_sweep (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       mode,
    input  logic [4:1] data_word,
    output logic [7:1] codeword,
    output logic [2:0] corrupt_index,
    output logic       trial_valid,
    input  logic       trial_ready,
    input  logic       result_valid,
    input  logic [4:1] result_data,
    input  logic [2:0] result_syndrome,
    output logic       busy,
    output logic       done,
    output logic [7:0] pass_count,
    output logic [7:0] fail_count
);

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_ISSUE = 3'd1,
        S_WAIT  = 3'd2,
        S_NEXT  = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    // Hamming(7,4) encoder; parity bits sit at the power-of-two positions.
    function automatic logic [7:1] hamming_encode(input logic [4:1] d);
        logic [7:1] c;
        c[3] = d[1];
        c[5] = d[2];
        c[6] = d[3];
        c[7] = d[4];
        c[1] = c[3] ^ c[5] ^ c[7];
        c[2] = c[3] ^ c[6] ^ c[7];
        c[4] = c[5] ^ c[6] ^ c[7];
        return c;
    endfunction

    // Counters stick at full scale instead of wrapping.
    function automatic logic [7:0] sat_inc(input logic [7:0] v);
        return (v == 8'hFF) ? v : (v + 8'd1);
    endfunction

    state_t     state_q, state_d;
    logic       mode_q,  mode_d;
    logic [4:1] data_q,  data_d;
    logic [2:0] index_q, index_d;
    logic [7:0] pass_q,  pass_d;
    logic [7:0] fail_q,  fail_d;
    logic       trial_valid_q;
    logic       busy_q;
    logic       done_q;

    // Next-state, sweep sequencing and scoring.
    always_comb begin
        state_d = state_q;
        mode_d  = mode_q;
        data_d  = data_q;
        index_d = index_q;
        pass_d  = pass_q;
        fail_d  = fail_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_ISSUE;
                    mode_d  = mode;
                    data_d  = mode ? 4'd0 : data_word;
                    index_d = 3'd0;
                    pass_d  = 8'd0;
                    fail_d  = 8'd0;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_ISSUE: begin
                if (trial_ready) begin
                    state_d = S_WAIT;
                end else begin
                    state_d = S_ISSUE;
                end
            end
            S_WAIT: begin
                if (result_valid) begin
                    state_d = S_NEXT;
                    if ((result_data == data_q) && (result_syndrome == index_q)) begin
                        pass_d = sat_inc(pass_q);
                    end else begin
                        fail_d = sat_inc(fail_q);
                    end
                end else begin
                    state_d = S_WAIT;
                end
            end
            S_NEXT: begin
                if (index_q != 3'd7) begin
                    index_d = index_q + 3'd1;
                    state_d = S_ISSUE;
                end else if (!mode_q || (data_q == 4'd15)) begin
                    state_d = S_DONE;
                end else begin
                    data_d  = data_q + 4'd1;
                    index_d = 3'd0;
                    state_d = S_ISSUE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State, sweep position, counters and registered status flags.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= S_IDLE;
            mode_q        <= 1'b0;
            data_q        <= 4'd0;
            index_q       <= 3'd0;
            pass_q        <= 8'd0;
            fail_q        <= 8'd0;
            trial_valid_q <= 1'b0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            mode_q        <= mode_d;
            data_q        <= data_d;
            index_q       <= index_d;
            pass_q        <= pass_d;
            fail_q        <= fail_d;
            trial_valid_q <= (state_d == S_ISSUE);
            busy_q        <= (state_d != S_IDLE);
            done_q        <= (state_d == S_DONE);
        end
    end

    assign codeword      = hamming_encode(data_q);
    assign corrupt_index = index_q;
    assign trial_valid   = trial_valid_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign pass_count    = pass_q;
    assign fail_count    = fail_q;

endmodule
